// File: rtl/cordic_iter_engine.sv
// cordic_iter_engine
// Iterative CORDIC shift-add datapath. One (x,y,z) operand is latched, then
// ITER micro-rotations are applied, one per clock, under control of an
// external direction-decision block that reads the low-order taps and
// returns dec_d (rotation sign) and dec_dn (hold) in the same cycle.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_ready only while idle
//   in_x, in_y, in_z      initial vector and angle (two's complement)
//   in_ex, in_ey          exponent tags, latched and exported unchanged
//   tap_valid             high while rotating; taps meaningful
//   tap_x/tap_y/tap_z     low bits of the registered x/y/z
//   tap_ex/tap_ey/tap_a   latched tags and current step index
//   dec_d, dec_dn         direction (1: sigma=+1) and hold, used only while rotating
//   out_valid/out_ready   result handshake
//   out_x, out_y, out_z   final registered x/y/z
//   busy                  engine not idle
module cordic_iter_engine #(
    parameter int W    = 16,
    parameter int ZW   = 16,
    parameter int ITER = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_x,
    input  logic [W-1:0]  in_y,
    input  logic [ZW-1:0] in_z,
    input  logic [2:0]    in_ex,
    input  logic [2:0]    in_ey,
    output logic          tap_valid,
    output logic [3:0]    tap_x,
    output logic [3:0]    tap_y,
    output logic [2:0]    tap_z,
    output logic [2:0]    tap_ex,
    output logic [2:0]    tap_ey,
    output logic [4:0]    tap_a,
    input  logic          dec_d,
    input  logic          dec_dn,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_x,
    output logic [W-1:0]  out_y,
    output logic [ZW-1:0] out_z,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [4:0] LAST = 5'(ITER - 1);
    // The arctangent table is held at 2^14 LSB per radian; rescale for other ZW.
    localparam int ZSH = (ZW >= 16) ? ZW - 16 : 0;
    localparam int ZSR = (ZW >= 16) ? 0 : 16 - ZW;

    state_t state, state_nx;

    logic signed [W-1:0]  x_reg, y_reg;
    logic signed [W-1:0]  x_sh, y_sh, x_nx, y_nx;
    logic signed [ZW-1:0] z_reg, z_nx, atan_i;
    logic [2:0]           ex_reg, ey_reg;
    logic [4:0]           i_reg;

    function automatic logic signed [ZW-1:0] atan_lut(input logic [4:0] idx);
        int v;
        case (idx)
            5'd0:    v = 12868;
            5'd1:    v = 7596;
            5'd2:    v = 4014;
            5'd3:    v = 2037;
            5'd4:    v = 1023;
            5'd5:    v = 512;
            5'd6:    v = 256;
            5'd7:    v = 128;
            5'd8:    v = 64;
            5'd9:    v = 32;
            5'd10:   v = 16;
            5'd11:   v = 8;
            5'd12:   v = 4;
            5'd13:   v = 2;
            5'd14:   v = 1;
            5'd15:   v = 1;
            default: v = 0;
        endcase
        v = (v <<< ZSH) >>> ZSR;
        return ZW'(v);
    endfunction

    // Micro-rotation candidate for the current step; adds wrap naturally.
    always_comb begin
        x_sh   = x_reg >>> i_reg;
        y_sh   = y_reg >>> i_reg;
        atan_i = atan_lut(i_reg);
        if (dec_d) begin
            x_nx = x_reg - y_sh;
            y_nx = y_reg + x_sh;
            z_nx = z_reg - atan_i;
        end else begin
            x_nx = x_reg + y_sh;
            y_nx = y_reg - x_sh;
            z_nx = z_reg + atan_i;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        tap_valid = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                tap_valid = 1'b1;
                if (!dec_dn && i_reg == LAST) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            x_reg  <= '0;
            y_reg  <= '0;
            z_reg  <= '0;
            ex_reg <= '0;
            ey_reg <= '0;
            i_reg  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg  <= in_x;
                        y_reg  <= in_y;
                        z_reg  <= in_z;
                        ex_reg <= in_ex;
                        ey_reg <= in_ey;
                        i_reg  <= '0;
                    end
                end
                RUN: begin
                    if (!dec_dn) begin
                        x_reg <= x_nx;
                        y_reg <= y_nx;
                        z_reg <= z_nx;
                        // The last step leaves i at ITER-1; DONE clears it.
                        if (i_reg != LAST) i_reg <= i_reg + 5'd1;
                    end
                end
                DONE: begin
                    // Step index returns to zero so idle taps read a clean index.
                    if (out_ready) i_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    assign tap_x  = x_reg[3:0];
    assign tap_y  = y_reg[3:0];
    assign tap_z  = z_reg[2:0];
    assign tap_ex = ex_reg;
    assign tap_ey = ey_reg;
    assign tap_a  = i_reg;
    assign out_x  = x_reg;
    assign out_y  = y_reg;
    assign out_z  = z_reg;

endmodule
